receiver: RTL and testbench

RECEIVER -- requirements
Module: receiver

---
 rtl/receiver_pkg.sv | 28 ++
 rtl/receiver.sv | 187 ++++++++++++++++++
 tb/tb_receiver.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/receiver_pkg.sv
// Shared constants and types for the host byte-stream receiver.
//   - frame marker bytes, command codes, burst-completion ack code
//   - receiver FSM state enum
package receiver_pkg;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned PAYLOAD_W = 32;
   localparam int unsigned COUNT_W   = 16;
   localparam int unsigned INDEX_W   = 3;

   localparam logic [BYTE_W-1:0] START_MARK = 8'h55;
   localparam logic [BYTE_W-1:0] PAD_BYTE   = 8'h00;
   localparam logic [BYTE_W-1:0] END_MARK   = 8'hAA;

   localparam logic [BYTE_W-1:0] CMD_PHASE  = 8'h01;
   localparam logic [BYTE_W-1:0] CMD_BURST  = 8'h02;
   localparam logic [BYTE_W-1:0] CMD_CALIB  = 8'h03;

   localparam logic [BYTE_W-1:0] ACK_BURST  = 8'h82;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      BURST = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/receiver.sv
// Host command receiver: pulls bytes from an RX FIFO, decodes 8-byte frames
// (55 | payload LE x4 | code | 00 | AA), drives strobes and writes ack bytes.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   rxfifo_*          RX FIFO side (rd request is combinational)
//   txfifo_*          TX FIFO side (ack bytes, dropped when full)
//   latest_data       last decoded payload / burst byte
//   phase_parse_en    one-cycle phase-write strobe
//   phase_calib_en    one-cycle calibration strobe
//   read_error        one-cycle framing/command error strobe
module receiver
   import receiver_pkg::*;
#(
   parameter int unsigned TX_FIFO_LOAD_W = 13,
   parameter int unsigned RX_FIFO_LOAD_W = 13
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                rxfifo_data,
   input  logic                      rxfifo_valid,
   input  logic [RX_FIFO_LOAD_W-1:0] rxfifo_load,
   input  logic                      rxfifo_empty,
   output logic                      rxfifo_rd,
   input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
   input  logic                      txfifo_full,
   output logic                      txfifo_wr,
   output logic [7:0]                txfifo_data,
   output logic [31:0]               latest_data,
   output logic                      phase_parse_en,
   output logic                      phase_calib_en,
   output logic                      read_error
);

   // Fill levels are informational only.
   logic unused_load;
   assign unused_load = ^{rxfifo_load, txfifo_load};

   state_t               state, state_nxt;
   logic [INDEX_W-1:0]   idx, idx_nxt;
   logic [PAYLOAD_W-1:0] payload, payload_nxt;
   logic [BYTE_W-1:0]    code, code_nxt;
   logic [BYTE_W-1:0]    pad, pad_nxt;
   logic [COUNT_W-1:0]   cnt, cnt_nxt;

   logic [PAYLOAD_W-1:0] latest_nxt;
   logic                 parse_nxt, calib_nxt, err_nxt;
   logic                 ack_req;
   logic [BYTE_W-1:0]    ack_byte;
   logic                 wr_nxt;
   logic [BYTE_W-1:0]    tx_data_nxt;
   logic                 consume;

   // Read whenever data is available and out of reset.
   assign rxfifo_rd = ~rxfifo_empty & rst;
   assign consume   = rxfifo_rd & rxfifo_valid;

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= IDLE;
         idx            <= '0;
         payload        <= '0;
         code           <= '0;
         pad            <= '0;
         cnt            <= '0;
         latest_data    <= '0;
         phase_parse_en <= 1'b0;
         phase_calib_en <= 1'b0;
         read_error     <= 1'b0;
         txfifo_wr      <= 1'b0;
         txfifo_data    <= '0;
      end else begin
         state          <= state_nxt;
         idx            <= idx_nxt;
         payload        <= payload_nxt;
         code           <= code_nxt;
         pad            <= pad_nxt;
         cnt            <= cnt_nxt;
         latest_data    <= latest_nxt;
         phase_parse_en <= parse_nxt;
         phase_calib_en <= calib_nxt;
         read_error     <= err_nxt;
         txfifo_wr      <= wr_nxt;
         txfifo_data    <= tx_data_nxt;
      end
   end

   // Next-state, frame decode and ack generation.
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      payload_nxt = payload;
      code_nxt    = code;
      pad_nxt     = pad;
      cnt_nxt     = cnt;
      latest_nxt  = latest_data;
      parse_nxt   = 1'b0;
      calib_nxt   = 1'b0;
      err_nxt     = 1'b0;
      ack_req     = 1'b0;
      ack_byte    = '0;
      wr_nxt      = 1'b0;
      tx_data_nxt = txfifo_data;

      case (state)
         // DONE acks the finished burst and otherwise behaves like IDLE,
         // since rxfifo_rd does not depend on state.
         IDLE, DONE: begin
            if (state == DONE) begin
               ack_req   = 1'b1;
               ack_byte  = ACK_BURST;
               state_nxt = IDLE;
            end
            if (consume) begin
               if (rxfifo_data == START_MARK) begin
                  state_nxt = FRAME;
                  idx_nxt   = INDEX_W'(1);
               end else begin
                  err_nxt   = 1'b1;
               end
            end
         end

         FRAME: begin
            if (consume) begin
               idx_nxt = idx + INDEX_W'(1);
               case (idx)
                  3'd1, 3'd2, 3'd3, 3'd4:
                     payload_nxt = {rxfifo_data, payload[PAYLOAD_W-1:BYTE_W]};
                  3'd5: code_nxt = rxfifo_data;
                  3'd6: pad_nxt  = rxfifo_data;
                  3'd7: begin
                     idx_nxt   = '0;
                     state_nxt = IDLE;
                     if (pad != PAD_BYTE || rxfifo_data != END_MARK) begin
                        err_nxt = 1'b1;
                     end else begin
                        case (code)
                           CMD_PHASE: begin
                              latest_nxt = payload;
                              parse_nxt  = 1'b1;
                              ack_req    = 1'b1;
                              ack_byte   = CMD_PHASE;
                           end
                           CMD_CALIB: begin
                              latest_nxt = payload;
                              calib_nxt  = 1'b1;
                              ack_req    = 1'b1;
                              ack_byte   = CMD_CALIB;
                           end
                           CMD_BURST: begin
                              latest_nxt = payload;
                              ack_req    = 1'b1;
                              ack_byte   = CMD_BURST;
                              cnt_nxt    = payload[COUNT_W-1:0];
                              if (payload[COUNT_W-1:0] != '0) state_nxt = BURST;
                           end
                           default: err_nxt = 1'b1;
                        endcase
                     end
                  end
                  default: ;
               endcase
            end
         end

         // Raw payload bytes; no marker checking.
         BURST: begin
            if (consume) begin
               latest_nxt = {24'h0, rxfifo_data};
               parse_nxt  = 1'b1;
               cnt_nxt    = cnt - COUNT_W'(1);
               if (cnt == COUNT_W'(1)) state_nxt = DONE;
            end
         end

         default: state_nxt = IDLE;
      endcase

      // Acks are dropped when the TX FIFO is full.
      if (ack_req && !txfifo_full) begin
         wr_nxt      = 1'b1;
         tx_data_nxt = ack_byte;
      end
   end

endmodule

// File: tb/tb_receiver.sv
// Directed self-checking bench for the receiver frame decoder.
module tb_receiver;

   logic        clk;
   logic        rst;
   logic [7:0]  rxfifo_data;
   logic        rxfifo_valid;
   logic [12:0] rxfifo_load;
   logic        rxfifo_empty;
   logic        rxfifo_rd;
   logic [12:0] txfifo_load;
   logic        txfifo_full;
   logic        txfifo_wr;
   logic [7:0]  txfifo_data;
   logic [31:0] latest_data;
   logic        phase_parse_en;
   logic        phase_calib_en;
   logic        read_error;

   int checks = 0;
   int errors = 0;

   receiver #(.TX_FIFO_LOAD_W(13), .RX_FIFO_LOAD_W(13)) dut (
      .clk            (clk),
      .rst            (rst),
      .rxfifo_data    (rxfifo_data),
      .rxfifo_valid   (rxfifo_valid),
      .rxfifo_load    (rxfifo_load),
      .rxfifo_empty   (rxfifo_empty),
      .rxfifo_rd      (rxfifo_rd),
      .txfifo_load    (txfifo_load),
      .txfifo_full    (txfifo_full),
      .txfifo_wr      (txfifo_wr),
      .txfifo_data    (txfifo_data),
      .latest_data    (latest_data),
      .phase_parse_en (phase_parse_en),
      .phase_calib_en (phase_calib_en),
      .read_error     (read_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic p, input logic c, input logic e,
                            input logic w, input logic [7:0] d, input logic [31:0] ld);
      check({tag, ".parse"}, 32'(phase_parse_en), 32'(p));
      check({tag, ".calib"}, 32'(phase_calib_en), 32'(c));
      check({tag, ".err"},   32'(read_error),     32'(e));
      check({tag, ".wr"},    32'(txfifo_wr),      32'(w));
      if (w) check({tag, ".txdata"}, 32'(txfifo_data), 32'(d));
      check({tag, ".latest"}, latest_data, ld);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one byte; it is consumed on the next edge.
   task automatic send_byte(input logic [7:0] b);
      rxfifo_data  = b;
      rxfifo_valid = 1'b1;
      rxfifo_empty = 1'b0;
      tick();
      rxfifo_valid = 1'b0;
      rxfifo_empty = 1'b1;
   endtask

   task automatic send_frame(input logic [31:0] pl, input logic [7:0] cmd,
                             input logic [7:0] b6, input logic [7:0] b7);
      send_byte(8'h55);
      send_byte(pl[7:0]);
      send_byte(pl[15:8]);
      send_byte(pl[23:16]);
      send_byte(pl[31:24]);
      send_byte(cmd);
      send_byte(b6);
      send_byte(b7);
   endtask

   initial begin
      rst          = 1'b0;
      rxfifo_data  = 8'h00;
      rxfifo_valid = 1'b0;
      rxfifo_empty = 1'b0;
      rxfifo_load  = 13'd5;
      txfifo_load  = 13'd0;
      txfifo_full  = 1'b0;
      tick();
      tick();

      // Reset: read request gated and all outputs clear.
      check("reset.rd", 32'(rxfifo_rd), 32'(0));
      check("reset.txdata", 32'(txfifo_data), 32'(0));
      check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      rxfifo_empty = 1'b1;
      rst = 1'b1;
      tick();
      check("rd_empty", 32'(rxfifo_rd), 32'(0));
      rxfifo_empty = 1'b0;
      #1;
      check("rd_avail", 32'(rxfifo_rd), 32'(1));
      rxfifo_empty = 1'b1;

      // PHASE frame.
      send_frame(32'h0001_0123, 8'h01, 8'h00, 8'hAA);
      check_out("phase", 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 32'h0001_0123);
      tick();
      check_out("phase_end", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0001_0123);

      // CALIB frame.
      send_frame(32'h0000_0023, 8'h03, 8'h00, 8'hAA);
      check_out("calib", 1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 32'h0000_0023);
      tick();
      check_out("calib_end", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0023);

      // Unknown command code.
      send_frame(32'h0000_0023, 8'h07, 8'h00, 8'hAA);
      check_out("badcmd", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0000_0023);
      tick();
      check("badcmd_end.err", 32'(read_error), 32'(0));

      // Bad end marker and bad pad byte.
      send_frame(32'h1234_5678, 8'h01, 8'h00, 8'hAB);
      check_out("badend", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0000_0023);
      send_frame(32'h1234_5678, 8'h01, 8'h01, 8'hAA);
      check_out("badpad", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0000_0023);

      // Junk byte in IDLE.
      send_byte(8'h3C);
      check_out("junk", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0000_0023);

      // BURST of 16 bytes, one with a stall in the middle.
      send_frame(32'h0000_0010, 8'h02, 8'h00, 8'hAA);
      check_out("burst_cmd", 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 32'h0000_0010);
      for (int i = 0; i < 16; i++) begin
         if (i == 8) begin
            tick();
            tick();
         end
         send_byte(8'(i));
         check_out($sformatf("burst_b%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'(i));
      end
      tick();
      check_out("burst_ack", 1'b0, 1'b0, 1'b0, 1'b1, 8'h82, 32'h0000_000F);
      tick();
      check("burst_ack_end.wr", 32'(txfifo_wr), 32'(0));

      // A following 0x55 is a start marker again, not burst data.
      send_frame(32'hDEAD_BEEF, 8'h01, 8'h00, 8'hAA);
      check_out("post_burst", 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 32'hDEAD_BEEF);

      // BURST with N=0 goes straight back to IDLE.
      send_frame(32'hABCD_0000, 8'h02, 8'h00, 8'hAA);
      check_out("burst0", 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 32'hABCD_0000);
      send_byte(8'h55);
      check("burst0_idle.err", 32'(read_error), 32'(0));
      check("burst0_idle.parse", 32'(phase_parse_en), 32'(0));
      send_byte(8'h44);
      send_byte(8'h33);
      send_byte(8'h22);
      send_byte(8'h11);
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'hAA);
      check_out("burst0_next", 1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 32'h1122_3344);

      // Valid-low stall mid-frame with TX FIFO full: decode, no ack.
      txfifo_full = 1'b1;
      send_byte(8'h55);
      send_byte(8'h78);
      send_byte(8'h56);
      rxfifo_empty = 1'b0;
      rxfifo_valid = 1'b0;
      rxfifo_data  = 8'hFF;
      tick();
      tick();
      send_byte(8'h34);
      send_byte(8'h12);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hAA);
      check_out("stall_full", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h1234_5678);
      txfifo_full = 1'b0;

      // Reset after 3 bytes abandons the frame.
      send_byte(8'h55);
      send_byte(8'h99);
      send_byte(8'h88);
      rst = 1'b0;
      rxfifo_empty = 1'b0;
      tick();
      check("midreset.rd", 32'(rxfifo_rd), 32'(0));
      check_out("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      rst = 1'b1;
      rxfifo_empty = 1'b1;
      send_frame(32'hCAFE_BABE, 8'h01, 8'h00, 8'hAA);
      check_out("after_reset", 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 32'hCAFE_BABE);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
